// File: rtl/exec_sequencer.sv
// exec_sequencer: drives the Execution datapath for one command at a time,
// iterating shift-add over the ALU adder for MUL and returning result/NZCV.
module exec_sequencer #(
  parameter int WIDTH     = 32,
  parameter int MUL_ITERS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [23:0]      cmd_imm,
  input  logic [1:0]       cmd_alusrc,
  input  logic [1:0]       cmd_immsrc,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic [WIDTH-1:0] ex_rd1,
  output logic [WIDTH-1:0] ex_rd2,
  output logic [23:0]      ex_imm,
  output logic [1:0]       ex_alusrc,
  output logic [1:0]       ex_immsrc,
  output logic [1:0]       ex_aluctrl,
  input  logic [3:0]       ex_flags,
  input  logic [WIDTH-1:0] ex_result
);
  localparam int CW = $clog2(MUL_ITERS + 1);
  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;
  state_t           r_state, w_next;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_mcand, r_mplier, r_result;
  logic [23:0]      r_imm;
  logic [1:0]       r_alusrc, r_immsrc;
  logic [3:0]       r_flags;
  logic             r_err;
  logic [CW-1:0]    r_cnt;
  logic             w_exec, w_mul, w_mul_done;
  assign w_exec     = r_state == EXEC;
  assign w_mul      = r_state == MUL;
  assign w_mul_done = r_cnt == CW'(MUL_ITERS);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (cmd_valid) w_next = cmd_op == 3'b101 ? MUL : (cmd_op[2] & cmd_op[1]) ? DONE : EXEC;
      EXEC:    w_next = DONE;
      MUL:     if (w_mul_done) w_next = DONE;
      DONE:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_imm    <= '0;
      r_alusrc <= '0;
      r_immsrc <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_flags  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (cmd_valid) begin
          r_op     <= cmd_op;
          r_a      <= cmd_a;
          r_b      <= cmd_b;
          r_imm    <= cmd_imm;
          r_alusrc <= cmd_alusrc;
          r_immsrc <= cmd_immsrc;
          r_acc    <= '0;
          r_mcand  <= cmd_a;
          r_mplier <= cmd_b;
          r_cnt    <= '0;
          r_result <= '0;
          r_err    <= cmd_op[2] & cmd_op[1];
        end
        EXEC: begin
          r_flags <= ex_flags;
          if (r_op != 3'b100) r_result <= ex_result;
        end
        MUL: if (w_mul_done) begin
          r_result <= r_acc;
          r_flags  <= {r_acc[WIDTH-1], r_acc == '0, 2'b00};
        end else begin
          if (r_mplier[0]) r_acc <= ex_result;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
  assign cmd_ready  = r_state == IDLE;
  assign rsp_valid  = r_state == DONE;
  assign rsp_result = r_result;
  assign rsp_flags  = r_flags;
  assign rsp_err    = r_err;
  // MUL reuses the adder: acc + mcand with SrcB forced to RD2
  assign ex_rd1     = w_exec ? r_a : w_mul ? r_acc : '0;
  assign ex_rd2     = w_exec ? r_b : w_mul ? r_mcand : '0;
  assign ex_imm     = w_exec ? r_imm : '0;
  assign ex_alusrc  = w_exec ? r_alusrc : 2'b00;
  assign ex_immsrc  = w_exec ? r_immsrc : 2'b00;
  assign ex_aluctrl = w_exec ? (r_op == 3'b100 ? 2'b01 : r_op[1:0]) : 2'b00;
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: vector table plus handshake corner cases against a
// behavioral Execution-stage model (extend, SrcB mux, ALU with NZCV).
module tb_exec_sequencer;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [2:0]  cmd_op = '0;
  logic [31:0] cmd_a = '0, cmd_b = '0, rsp_result, ex_rd1, ex_rd2, ex_result;
  logic [23:0] cmd_imm = '0, ex_imm;
  logic [1:0]  cmd_alusrc = '0, cmd_immsrc = '0, ex_alusrc, ex_immsrc, ex_aluctrl;
  logic [3:0]  rsp_flags, ex_flags;
  int n_checks = 0, n_fail = 0;

  exec_sequencer #(.WIDTH(32), .MUL_ITERS(32)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_imm(cmd_imm), .cmd_alusrc(cmd_alusrc),
    .cmd_immsrc(cmd_immsrc), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err), .ex_rd1(ex_rd1),
    .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_alusrc(ex_alusrc), .ex_immsrc(ex_immsrc),
    .ex_aluctrl(ex_aluctrl), .ex_flags(ex_flags), .ex_result(ex_result)
  );

  always #5 clk = ~clk;

  logic [31:0] w_ext, w_srcb;
  logic [32:0] w_full;
  logic        w_v;
  always_comb begin
    w_ext  = ex_immsrc == 2'b00 ? {24'b0, ex_imm[7:0]} :
             ex_immsrc == 2'b01 ? {20'b0, ex_imm[11:0]} : {{6{ex_imm[23]}}, ex_imm, 2'b00};
    w_srcb = ex_alusrc == 2'b00 ? ex_rd2 : w_ext;
    w_full = ex_aluctrl[0] ? {1'b0, ex_rd1} + {1'b0, ~w_srcb} + 33'd1 : {1'b0, ex_rd1} + {1'b0, w_srcb};
    ex_result = ex_aluctrl[1] ? (ex_aluctrl[0] ? ex_rd1 | w_srcb : ex_rd1 & w_srcb) : w_full[31:0];
    w_v = ~(ex_aluctrl[0] ^ ex_rd1[31] ^ w_srcb[31]) & (ex_rd1[31] ^ w_full[31]);
    ex_flags = {ex_result[31], ex_result == 32'd0, ~ex_aluctrl[1] & w_full[32], ~ex_aluctrl[1] & w_v};
  end

  typedef struct {
    logic [2:0] op; logic [31:0] a, b; logic [23:0] imm; logic [1:0] alusrc, immsrc;
    logic [31:0] res; logic [3:0] flags; logic err; int lat;
  } vec_t;
  typedef struct { logic [31:0] res; logic [3:0] flags; logic err; int lat; } exp_t;
  vec_t vecs[12];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_rsp(input int hold);
    int lat = 0;
    exp_t e;
    while (1) begin
      @(negedge clk);
      lat++;
      if (rsp_valid || lat >= 100) break;
      check("busy_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    end
    e = sb.pop_front();
    check("latency", lat, e.lat);
    check("result", rsp_result, e.res);
    check("flags", {28'b0, rsp_flags}, {28'b0, e.flags});
    check("err", {31'b0, rsp_err}, {31'b0, e.err});
    for (int i = 0; i < hold; i++) begin
      cmd_valid = (i == 2);
      cmd_a = 32'd9;
      cmd_b = 32'd9;
      @(negedge clk);
      check("hold_valid", {31'b0, rsp_valid}, 32'd1);
      check("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      check("hold_result", rsp_result, e.res);
      check("hold_flags", {28'b0, rsp_flags}, {28'b0, e.flags});
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic issue(input vec_t v, input int hold);
    @(negedge clk);
    cmd_op = v.op; cmd_a = v.a; cmd_b = v.b; cmd_imm = v.imm;
    cmd_alusrc = v.alusrc; cmd_immsrc = v.immsrc; cmd_valid = 1'b1;
    sb.push_back('{v.res, v.flags, v.err, v.lat});
    check("accept_ready", {31'b0, cmd_ready}, 32'd1);
    check("idle_ex_rd1", ex_rd1, 32'd0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_rsp(hold);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{3'b000, 32'hFFFFFFFF, 32'h1, 24'h0, 2'b00, 2'b00, 32'h0, 4'b0110, 1'b0, 2};
    vecs[1]  = '{3'b001, 32'd3, 32'd5, 24'h0, 2'b00, 2'b00, 32'hFFFFFFFE, 4'b1000, 1'b0, 2};
    vecs[2]  = '{3'b100, 32'd7, 32'd7, 24'h0, 2'b00, 2'b00, 32'h0, 4'b0110, 1'b0, 2};
    vecs[3]  = '{3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 24'h0, 2'b00, 2'b00, 32'hF000F000, 4'b1000, 1'b0, 2};
    vecs[4]  = '{3'b011, 32'h0F, 32'h30, 24'h0, 2'b00, 2'b00, 32'h3F, 4'b0000, 1'b0, 2};
    vecs[5]  = '{3'b000, 32'h100, 32'hDEAD, 24'h123, 2'b01, 2'b01, 32'h223, 4'b0000, 1'b0, 2};
    vecs[6]  = '{3'b000, 32'h7FFFFFFF, 32'h1, 24'h0, 2'b00, 2'b00, 32'h80000000, 4'b1001, 1'b0, 2};
    vecs[7]  = '{3'b101, 32'd1234, 32'd5678, 24'h0, 2'b00, 2'b00, 32'h006AE9BC, 4'b0000, 1'b0, 34};
    vecs[8]  = '{3'b101, 32'h10000, 32'h10000, 24'h0, 2'b00, 2'b00, 32'h0, 4'b0100, 1'b0, 34};
    vecs[9]  = '{3'b110, 32'd5, 32'd6, 24'h0, 2'b00, 2'b00, 32'h0, 4'b0100, 1'b1, 1};
    vecs[10] = '{3'b111, 32'd5, 32'd6, 24'h0, 2'b00, 2'b00, 32'h0, 4'b0100, 1'b1, 1};
    vecs[11] = '{3'b101, 32'hFFFFFFFF, 32'd3, 24'h0, 2'b00, 2'b00, 32'hFFFFFFFD, 4'b1000, 1'b0, 34};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_result", rsp_result, 32'd0);
    check("rst_flags", {28'b0, rsp_flags}, 32'd0);
    check("rst_ex", {ex_rd2[27:0], ex_aluctrl, ex_alusrc}, 32'd0);
    for (int i = 0; i < 12; i++) issue(vecs[i], 0);
    issue('{3'b000, 32'd2, 32'd2, 24'h0, 2'b00, 2'b00, 32'd4, 4'b0000, 1'b0, 2}, 5);
    issue(vecs[1], 0);
    @(negedge clk);
    cmd_op = 3'b101; cmd_a = 32'd1234; cmd_b = 32'd5678; cmd_alusrc = 2'b00; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("abort_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("abort_flags", {28'b0, rsp_flags}, 32'd0);
    check("abort_ex_rd2", ex_rd2, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    issue('{3'b000, 32'd1, 32'd1, 24'h0, 2'b00, 2'b00, 32'd2, 4'b0000, 1'b0, 2}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
